// File: rtl/simd_aes_pkg.sv
// -----------------------------------------------------------------------------
// simd_aes_pkg
// Shared types for the AES decrypt/encrypt datapath of the SIMD processor.
//   NB          : columns per AES state (and bytes per column)
//   byte_t      : one state byte
//   word_t      : one state column; byte[31:24] is row 0, byte[7:0] is row 3
//   state_t     : a full 128-bit state as NB column words
//   sr_state_e  : FILL/DRAIN phases of the word-serial ShiftRows units
// -----------------------------------------------------------------------------
package simd_aes_pkg;

    localparam int NB = 4;

    typedef logic [7:0]       byte_t;
    typedef logic [31:0]      word_t;
    typedef word_t [NB-1:0]   state_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } sr_state_e;

    // Row r of a column word (row 0 sits in the most significant byte).
    function automatic byte_t get_row(input word_t w, input logic [1:0] r);
        return w[8*(3-int'(r)) +: 8];
    endfunction

endpackage

// File: rtl/shift_rows_col_sel.sv
// -----------------------------------------------------------------------------
// shift_rows_col_sel
// Combinational selector producing one output column of (Inv)ShiftRows from a
// fully buffered state.
//   state : buffered state, state[c] is input column c
//   col   : output column index
//   fwd   : 1 = forward ShiftRows  (row r taken from column col + r)
//           0 = inverse ShiftRows  (row r taken from column col - r)
//   word  : selected output column
// -----------------------------------------------------------------------------
module shift_rows_col_sel
    import simd_aes_pkg::*;
(
    input  state_t      state,
    input  logic [1:0]  col,
    input  logic        fwd,
    output word_t       word
);

    always_comb begin
        word = '0;
        for (int r = 0; r < NB; r++) begin
            // 2-bit index arithmetic gives the mod-4 column rotation for free.
            word[8*(NB-1-r) +: 8] =
                get_row(state[fwd ? (col + 2'(r)) : (col - 2'(r))], 2'(r));
        end
    end

endmodule

// File: rtl/inv_shift_rows_stream.sv
// -----------------------------------------------------------------------------
// inv_shift_rows_stream
// Word-serial AES InvShiftRows. Collects a 128-bit state as 4 column words,
// then emits the 4 shifted columns. Filling and draining never overlap, so a
// block takes at least 8 cycles.
//
// Handshake: a beat moves on a rising clk edge where valid && ready are both
// high; valid never depends on ready, and out_word/out_last hold steady while
// out_valid is high and out_ready is low.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input column stream handshake
//   in_word              input column (byte[31:24] = row 0 ... byte[7:0] = row 3)
//   out_valid/out_ready  output column stream handshake
//   out_word             output column, same byte layout (0 when out_valid=0)
//   out_last             high with output column 3 of a block
//   fwd                  (only with SHIFT_ROWS_DIR_SEL_EN) 1 = forward
//                        ShiftRows, sampled on the first beat of each block
//
// Build option: define SHIFT_ROWS_DIR_SEL_EN to add the fwd direction select;
// otherwise the block performs inverse ShiftRows only.
// -----------------------------------------------------------------------------
module inv_shift_rows_stream
    import simd_aes_pkg::*;
#(
    parameter int regSize = 32,   // column width, must be 8*vecSize
    parameter int vecSize = 4     // columns per state, fixed at 4 for AES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [regSize-1:0] in_word,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [regSize-1:0] out_word,
    output logic               out_last
`ifdef SHIFT_ROWS_DIR_SEL_EN
    ,
    input  logic               fwd
`endif
);

    localparam logic [1:0] LAST_IDX = 2'(vecSize - 1);

    sr_state_e  state_q;
    logic [1:0] wr_cnt;
    logic [1:0] rd_cnt;
    state_t     buf_q;
    logic       in_ready_q;
    logic       out_valid_q;
    logic       out_last_q;
    logic       dir;
    word_t      sel_word;

    logic accept;
    logic xfer;

    assign accept = in_valid && in_ready_q;
    assign xfer   = out_valid_q && out_ready;

`ifdef SHIFT_ROWS_DIR_SEL_EN
    logic dir_q;

    // Direction is latched with the first column so a block is never split
    // between two directions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
        end else if (state_q == FILL && accept && wr_cnt == 2'd0) begin
            dir_q <= fwd;
        end
    end

    assign dir = dir_q;
`else
    assign dir = 1'b0;
`endif

    // Control FSM. in_ready/out_valid/out_last are registered so they come
    // straight from flops; in_ready stays low during reset and rises on the
    // first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wr_cnt      <= 2'd0;
            rd_cnt      <= 2'd0;
            buf_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        buf_q[wr_cnt] <= word_t'(in_word);
                        wr_cnt        <= wr_cnt + 2'd1;
                        if (wr_cnt == LAST_IDX) begin
                            state_q     <= DRAIN;
                            rd_cnt      <= 2'd0;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        rd_cnt     <= rd_cnt + 2'd1;
                        // Column 3 is next when column 2 leaves.
                        out_last_q <= (rd_cnt == LAST_IDX - 2'd1);
                        if (rd_cnt == LAST_IDX) begin
                            state_q     <= FILL;
                            wr_cnt      <= 2'd0;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= FILL;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output column is a pure function of the buffer and rd_cnt, so there is
    // no combinational path from the input stream to the output stream.
    shift_rows_col_sel u_col_sel (
        .state (buf_q),
        .col   (rd_cnt),
        .fwd   (dir),
        .word  (sel_word)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_word  = out_valid_q ? regSize'(sel_word) : '0;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
module tb_inv_shift_rows_stream;

    typedef logic [31:0] blk_t [4];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_last;
`ifdef SHIFT_ROWS_DIR_SEL_EN
    logic        fwd;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    bit          cur_fwd = 1'b0;

    inv_shift_rows_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_last  (out_last)
`ifdef SHIFT_ROWS_DIR_SEL_EN
        ,
        .fwd       (fwd)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // State as a 4x4 byte matrix s[row][col]; ShiftRows rotates row r left by
    // r positions, InvShiftRows rotates it right by r positions.
    function automatic void model_push(input blk_t w, input bit f);
        logic [7:0]  s [4][4];
        logic [31:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = w[c][8*(3-r) +: 8];
        for (int c = 0; c < 4; c++) begin
            o = '0;
            for (int r = 0; r < 4; r++)
                o[8*(3-r) +: 8] = f ? s[r][(c + r) % 4] : s[r][(c + 4 - r) % 4];
            exp_q.push_back(o);
        end
    endfunction

    // ---------------- drivers ----------------
    // Enter and leave at a negedge. Drives 4 beats (optionally with idle gaps
    // carrying a decoy word), then checks that out_valid rose one cycle later.
    task automatic feed_block(input blk_t w, input bit gaps);
        int i     = 0;
        int guard = 0;
        bit gap   = 1'b0;
`ifdef SHIFT_ROWS_DIR_SEL_EN
        fwd = cur_fwd;
`endif
        while (i < 4 && guard < 200) begin
            @(negedge clk);
            guard++;
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL fill_flags: in_ready=%b out_valid=%b required in_ready=1 out_valid=0",
                         in_ready, out_valid);
            end
            if (gaps && gap) begin
                in_valid = 1'b0;
                in_word  = 32'hdeadbeef;
            end else begin
                in_valid = 1'b1;
                in_word  = w[i];
                i++;
            end
            if (gaps) gap = !gap;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fill_timeout: beats=%0d required 4", i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_word  = $urandom;
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_latency: out_valid=%b in_ready=%b required out_valid=1 in_ready=0",
                     out_valid, in_ready);
        end
    endtask

    // Consumes max_words outputs against exp_q. Stalls for stall_first cycles
    // first, then optionally stalls randomly. Drives junk in_valid beats that
    // must be ignored while draining.
    task automatic drain_block(input int stall_first, input bit rand_stall, input int max_words);
        int          cnt   = 0;
        int          guard = 0;
        int          stall = stall_first;
        logic [31:0] e;
        while (cnt < max_words && guard < 200) begin
            guard++;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL drain_flags: out_valid=%b in_ready=%b required out_valid=1 in_ready=0",
                         out_valid, in_ready);
            end
            in_valid = 1'($urandom_range(0, 1));
            in_word  = $urandom;
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else begin
                out_ready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL exp_empty: got out_word=%h with nothing expected", out_word);
                cnt = max_words;
            end else if (out_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (out_word !== e || out_last !== (cnt == 3)) begin
                    n_bad++;
                    $display("FAIL out_word[%0d]: got %h last=%b required %h last=%b",
                             cnt, out_word, out_last, e, (cnt == 3));
                end
                cnt++;
            end else begin
                n_cmp++;
                if (out_word !== exp_q[0] || out_last !== (cnt == 3)) begin
                    n_bad++;
                    $display("FAIL stall_hold[%0d]: got %h last=%b required %h last=%b",
                             cnt, out_word, out_last, exp_q[0], (cnt == 3));
                end
            end
            @(negedge clk);
        end
        if (guard >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: words=%0d required %0d", cnt, max_words);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic push_inv_vector();
        exp_q.push_back(32'h63637c7c);
        exp_q.push_back(32'h7b7bc5c5);
        exp_q.push_back(32'h7676c0c0);
        exp_q.push_back(32'h7575d2d2);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        out_ready = 1'b0;
`ifdef SHIFT_ROWS_DIR_SEL_EN
        fwd = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_word !== 32'h0 || out_last !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_word=%h out_last=%b required 0/0/0/0",
                     in_ready, out_valid, out_word, out_last);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    blk_t blk_a = '{32'h637bc0d2, 32'h7b76d27c, 32'h76757cc5, 32'h7563c5c0};

    task automatic test_inverse_basic();
        push_inv_vector();
        feed_block(blk_a, 1'b0);
        drain_block(0, 1'b0, 4);
    endtask

    task automatic test_backpressure();
        push_inv_vector();
        feed_block(blk_a, 1'b0);
        drain_block(3, 1'b0, 4);
    endtask

    task automatic test_input_gaps();
        push_inv_vector();
        feed_block(blk_a, 1'b1);
        drain_block(0, 1'b0, 4);
    endtask

    task automatic test_back_to_back();
        blk_t blk_b = '{32'ha5a5a5a5, 32'ha5a5a5a5, 32'ha5a5a5a5, 32'ha5a5a5a5};
        push_inv_vector();
        feed_block(blk_a, 1'b0);
        drain_block(0, 1'b0, 4);
        for (int k = 0; k < 4; k++) exp_q.push_back(32'ha5a5a5a5);
        feed_block(blk_b, 1'b0);
        drain_block(0, 1'b0, 4);
    endtask

    task automatic test_reset_mid_drain();
        push_inv_vector();
        feed_block(blk_a, 1'b0);
        drain_block(0, 1'b0, 2);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_word !== 32'h0 || out_last !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_drain: out_valid=%b in_ready=%b out_word=%h out_last=%b required 0/0/0/0",
                     out_valid, in_ready, out_word, out_last);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL post_reset_idle: out_valid=%b required 0", out_valid);
            end
        end
        push_inv_vector();
        feed_block(blk_a, 1'b0);
        drain_block(0, 1'b0, 4);
    endtask

    task automatic test_random();
        blk_t w;
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 4; k++) w[k] = $urandom;
`ifdef SHIFT_ROWS_DIR_SEL_EN
            cur_fwd = 1'($urandom_range(0, 1));
`endif
            model_push(w, cur_fwd);
            feed_block(w, 1'($urandom_range(0, 1)));
            drain_block(int'($urandom_range(0, 2)), 1'b1, 4);
        end
        cur_fwd = 1'b0;
    endtask

`ifdef SHIFT_ROWS_DIR_SEL_EN
    task automatic test_fwd();
        blk_t w = '{32'h63637c7c, 32'h7b7bc5c5, 32'h7676c0c0, 32'h7575d2d2};
        cur_fwd = 1'b1;
        exp_q.push_back(32'h637bc0d2);
        exp_q.push_back(32'h7b76d27c);
        exp_q.push_back(32'h76757cc5);
        exp_q.push_back(32'h7563c5c0);
        feed_block(w, 1'b0);
        drain_block(0, 1'b0, 4);
        cur_fwd = 1'b0;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_inverse_basic();
        test_backpressure();
        test_input_gaps();
        test_back_to_back();
        test_reset_mid_drain();
`ifdef SHIFT_ROWS_DIR_SEL_EN
        test_fwd();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
